// File: rtl/spram_arb_ctrl.sv
// spram_arb_ctrl
// Shares one single-port scratch RAM between a write requester (loader) and a
// read requester (convolution engine). Arbitration is round-robin on
// contention, grants are combinational (zero-latency ready), read data comes
// back one cycle after acceptance with a qualifying pulse, and any access at
// or beyond DEPTH is accepted but neutralised and flagged in a sticky error bit.
module spram_arb_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 18,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  // write requester
  input  logic                     wr_valid,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic                     wr_ready,
  // read requester
  input  logic                     rd_valid,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_ready,
  output logic                     rd_rvalid,
  output logic signed [DATA_W-1:0] rd_rdata,
  // RAM port
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic signed [DATA_W-1:0] ram_wdata,
  input  logic signed [DATA_W-1:0] ram_rdata,
  // error reporting
  input  logic                     err_clr,
  output logic                     err_oor
);

  // DEPTH widened by one bit so that DEPTH == 2**ADDR_W still compares cleanly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  // Registered state: last_grant_reg is 0 when the write side won last, 1 when
  // the read side won last. oor_d_reg remembers that the read returning this
  // cycle was out of range so its (meaningless) RAM data is masked.
  logic last_grant_reg, last_grant_next;
  logic rd_rvalid_reg,  rd_rvalid_next;
  logic oor_d_reg,      oor_d_next;
  logic err_oor_reg,    err_oor_next;

  logic grant_wr;
  logic grant_rd;
  logic wr_oor;
  logic rd_oor;
  logic oor_hit;

  // Range checks and round-robin grant decision.
  always_comb begin
    wr_oor   = ({1'b0, wr_addr} >= DEPTH_L);
    rd_oor   = ({1'b0, rd_addr} >= DEPTH_L);
    // On contention the side that did not win last time gets the port.
    grant_wr = wr_valid && (!rd_valid || last_grant_reg);
    grant_rd = rd_valid && (!wr_valid || !last_grant_reg);
    oor_hit  = (grant_wr && wr_oor) || (grant_rd && rd_oor);
  end

  // Handshake and RAM port drive; the port idles at all-zero.
  always_comb begin
    wr_ready  = grant_wr;
    rd_ready  = grant_rd;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_wr) begin
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
      // Out-of-range writes are accepted but never reach the RAM; reset also
      // blocks writes so a requester mid-transfer cannot corrupt contents.
      ram_we    = !wr_oor && !rst;
    end else if (grant_rd) begin
      ram_addr  = rd_addr;
    end
  end

  // Next-state logic for arbitration history, read return and error flag.
  always_comb begin
    last_grant_next = last_grant_reg;
    rd_rvalid_next  = grant_rd;
    oor_d_next      = grant_rd && rd_oor;
    err_oor_next    = err_oor_reg;
    if (grant_wr) begin
      last_grant_next = 1'b0;
    end else if (grant_rd) begin
      last_grant_next = 1'b1;
    end
    // A new out-of-range access beats a simultaneous clear.
    if (oor_hit) begin
      err_oor_next = 1'b1;
    end else if (err_clr) begin
      err_oor_next = 1'b0;
    end
  end

  // State registers; reset makes the write side win the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
      rd_rvalid_reg  <= 1'b0;
      oor_d_reg      <= 1'b0;
      err_oor_reg    <= 1'b0;
    end else begin
      last_grant_reg <= last_grant_next;
      rd_rvalid_reg  <= rd_rvalid_next;
      oor_d_reg      <= oor_d_next;
      err_oor_reg    <= err_oor_next;
    end
  end

  // Read return path: RAM data is only trusted for in-range reads.
  always_comb begin
    rd_rvalid = rd_rvalid_reg;
    err_oor   = err_oor_reg;
    rd_rdata  = oor_d_reg ? '0 : ram_rdata;
  end

endmodule

// File: tb/tb_spram_arb_ctrl.sv
// Testbench for spram_arb_ctrl: directed scenarios plus randomized traffic,
// checked against a transaction-level reference model (word array, last
// winner, pending read result, sticky error) and a behavioural RAM.
module tb_spram_arb_ctrl;

  localparam int AW  = 5;
  localparam int DEP = 18;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic          rd_rvalid;
  logic [DW-1:0] rd_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          err_clr;
  logic          err_oor;

  spram_arb_ctrl #(.ADDR_W(AW), .DEPTH(DEP), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .rd_rvalid (rd_rvalid),
    .rd_rdata  (rd_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .err_clr   (err_clr),
    .err_oor   (err_oor)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read; addresses past DEPTH
  // return a non-zero junk pattern so unmasked data would be visible.
  logic [DW-1:0] ram_mem [32];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= (int'(ram_addr) < DEP) ? ram_mem[ram_addr] : 8'h5A;
  end

  // Reference model state
  logic [DW-1:0] model_mem [DEP];
  byte           last_winner;
  logic          exp_rv;
  logic [DW-1:0] exp_rd;
  logic          exp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, n_cycle);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return AW'($urandom_range(DEP, 31));
    return AW'($urandom_range(0, DEP - 1));
  endfunction

  // One clock cycle: drive requests (called just after a rising edge), check
  // everything at the falling edge, advance the model, return after the edge.
  task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic rv, input logic [AW-1:0] ra, input logic ec,
                      output logic gw, output logic gr);
    logic          w_oor;
    logic          r_oor;
    logic [AW-1:0] e_addr;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; err_clr = ec;
    w_oor = (int'(wa) >= DEP);
    r_oor = (int'(ra) >= DEP);
    if (wv && rv) begin
      gw = (last_winner == "R");
      gr = !gw;
    end else begin
      gw = wv;
      gr = rv;
    end
    e_addr = gw ? wa : (gr ? ra : '0);
    @(negedge clk);
    check_eq("wr_ready", 32'(wr_ready), 32'(gw));
    check_eq("rd_ready", 32'(rd_ready), 32'(gr));
    check_eq("one_grant", 32'(wr_ready & rd_ready), 32'(0));
    check_eq("ram_we", 32'(ram_we), 32'(gw && !w_oor));
    check_eq("ram_addr", 32'(ram_addr), 32'(e_addr));
    if (gw) check_eq("ram_wdata", 32'(ram_wdata), 32'(wd));
    else if (!gr) check_eq("ram_wdata_idle", 32'(ram_wdata), 32'(0));
    check_eq("rd_rvalid", 32'(rd_rvalid), 32'(exp_rv));
    if (exp_rv) check_eq("rd_rdata", 32'(rd_rdata), 32'(exp_rd));
    check_eq("err_oor", 32'(err_oor), 32'(exp_err));
    if (gw) $display("cyc %0d W addr=%0d data=%0d%s", n_cycle, wa, $signed(wd), w_oor ? " oor" : "");
    if (gr) $display("cyc %0d R addr=%0d%s", n_cycle, ra, r_oor ? " oor" : "");
    // advance model
    exp_rv = gr;
    exp_rd = (gr && !r_oor) ? model_mem[ra] : '0;
    if (gw && !w_oor) model_mem[wa] = wd;
    if ((gw && w_oor) || (gr && r_oor)) exp_err = 1'b1;
    else if (ec) exp_err = 1'b0;
    if (gw) last_winner = "W";
    else if (gr) last_winner = "R";
    n_cycle++;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_rv      = 1'b0;
    exp_rd      = '0;
    exp_err     = 1'b0;
    last_winner = "R";
  endtask

  logic          gw, gr;
  logic          wq_v, rq_v;
  logic [AW-1:0] wq_a, rq_a;
  logic [DW-1:0] wq_d;

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; err_clr = 1'b0;
    for (int i = 0; i < 32; i++) ram_mem[i] = DW'($urandom);
    for (int i = 0; i < DEP; i++) model_mem[i] = ram_mem[i];
    model_reset();

    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_eq("rst_rd_rvalid", 32'(rd_rvalid), 32'(0));
    check_eq("rst_err_oor", 32'(err_oor), 32'(0));
    check_eq("rst_wr_ready", 32'(wr_ready), 32'(0));
    check_eq("rst_rd_ready", 32'(rd_ready), 32'(0));
    check_eq("rst_ram_we", 32'(ram_we), 32'(0));
    check_eq("rst_ram_addr", 32'(ram_addr), 32'(0));
    check_eq("rst_ram_wdata", 32'(ram_wdata), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Write -5 to addr 3, read it back
    step(1'b1, 5'd3, 8'hFB, 1'b0, 5'd0, 1'b0, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 1'b0, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, gw, gr);

    // Four cycles of contention: W, R, W, R
    step(1'b1, 5'd0, 8'd11, 1'b1, 5'd2, 1'b0, gw, gr);
    step(1'b1, 5'd1, 8'd12, 1'b1, 5'd2, 1'b0, gw, gr);
    step(1'b1, 5'd1, 8'd12, 1'b1, 5'd3, 1'b0, gw, gr);
    step(1'b1, 5'd4, 8'd13, 1'b1, 5'd3, 1'b0, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, gw, gr);

    // Out-of-range write and read, then clear
    step(1'b1, 5'd18, 8'd99, 1'b0, 5'd0, 1'b0, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b1, 5'd31, 1'b0, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b1, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, gw, gr);

    // Clear coinciding with a new out-of-range access keeps the flag set
    step(1'b1, 5'd20, 8'd7, 1'b0, 5'd0, 1'b1, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b1, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, gw, gr);

    // Fill every word, then stream all reads back-to-back
    for (int i = 0; i < DEP; i++) step(1'b1, AW'(i), DW'(i), 1'b0, 5'd0, 1'b0, gw, gr);
    for (int i = 0; i < DEP; i++) step(1'b0, 5'd0, 8'h00, 1'b1, AW'(i), 1'b0, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, gw, gr);

    // Randomized traffic: requesters hold until accepted, occasionally drop
    wq_v = 1'b0; rq_v = 1'b0; wq_a = '0; rq_a = '0; wq_d = '0;
    for (int c = 0; c < 400; c++) begin
      if (!wq_v) begin
        if ($urandom_range(0, 99) < 60) begin
          wq_v = 1'b1; wq_a = rand_addr(); wq_d = DW'($urandom);
        end
      end else if ($urandom_range(0, 99) < 5) begin
        wq_v = 1'b0;
      end
      if (!rq_v) begin
        if ($urandom_range(0, 99) < 60) begin
          rq_v = 1'b1; rq_a = rand_addr();
        end
      end else if ($urandom_range(0, 99) < 5) begin
        rq_v = 1'b0;
      end
      step(wq_v, wq_a, wq_d, rq_v, rq_a, ($urandom_range(0, 9) == 0), gw, gr);
      if (gw) wq_v = 1'b0;
      if (gr) rq_v = 1'b0;
    end
    step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, gw, gr);

    // Reset mid-operation
    step(1'b0, 5'd0, 8'h00, 1'b1, 5'd5, 1'b0, gw, gr);
    check_eq("rvalid_before_rst", 32'(rd_rvalid), 32'(1));
    rd_valid = 1'b1; rd_addr = 5'd6;
    wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 8'd55;
    rst = 1'b1;
    #1;
    check_eq("rvalid_async_clr", 32'(rd_rvalid), 32'(0));
    @(negedge clk);
    check_eq("ram_we_in_rst", 32'(ram_we), 32'(0));
    @(posedge clk); #1;
    check_eq("rvalid_after_rst_read", 32'(rd_rvalid), 32'(0));
    check_eq("err_after_rst", 32'(err_oor), 32'(0));
    rst = 1'b0;
    wr_valid = 1'b0; rd_valid = 1'b0;
    model_reset();
    // First contention after reset goes to the write side; RAM keeps contents
    step(1'b1, 5'd4, 8'd77, 1'b1, 5'd5, 1'b0, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b1, 5'd5, 1'b0, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b1, 5'd4, 1'b0, gw, gr);
    step(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 1'b0, gw, gr);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
